// File: rtl/i2c_slave_responder.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match, byte-wide user port.
// Define I2C_SLAVE_CLK_STRETCH_EN to hold SCL low while waiting for read data (rd_valid_i).
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'b110_1000,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic       pclk,
    input  logic       areset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       scl_oe_o,
    output logic       wr_valid_o,
    output logic [7:0] wr_data_o,
    output logic       rd_req_o,
    input  logic       rd_valid_i,
    input  logic [7:0] rd_data_i,
    output logic       busy_o
);
    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_WR_DATA   = 4'd3;
    localparam logic [3:0] ST_WR_ACK    = 4'd4;
    localparam logic [3:0] ST_RD_LOAD   = 4'd5;
    localparam logic [3:0] ST_RD_DATA   = 4'd6;
    localparam logic [3:0] ST_RD_ACK    = 4'd7;
    localparam logic [3:0] ST_WAIT_STOP = 4'd8;

    logic [NSYNC-1:0] scl_sync_reg, sda_sync_reg;
    logic             scl_prev_reg, sda_prev_reg;
    logic             scl_s, sda_s;
    logic             scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

    logic [3:0] state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [6:0] rx_shift_reg, rx_shift_next;
    logic [6:0] tx_shift_reg, tx_shift_next;
    logic       rw_reg, rw_next;
    logic       ack_seen_reg, ack_seen_next;
    logic       req_sent_reg, req_sent_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       scl_oe_reg, scl_oe_next;
    logic       wr_valid_reg, wr_valid_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic       busy_reg, busy_next;

    // Sync flops reset high so an idle bus produces no spurious edges after reset.
    always_ff @(posedge pclk) begin
        if (areset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[NSYNC-2:0], scl_i};
            sda_sync_reg <= {sda_sync_reg[NSYNC-2:0], sda_i};
            scl_prev_reg <= scl_s;
            sda_prev_reg <= sda_s;
        end
    end

    assign scl_s     = scl_sync_reg[NSYNC-1];
    assign sda_s     = sda_sync_reg[NSYNC-1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    assign sda_rise  = sda_s & ~sda_prev_reg;
    assign sda_fall  = ~sda_s & sda_prev_reg;
    assign start_det = sda_fall & scl_s & scl_prev_reg;
    assign stop_det  = sda_rise & scl_s & scl_prev_reg;

    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        rx_shift_next = rx_shift_reg;
        tx_shift_next = tx_shift_reg;
        rw_next       = rw_reg;
        ack_seen_next = ack_seen_reg;
        req_sent_next = req_sent_reg;
        sda_oe_next   = sda_oe_reg;
        scl_oe_next   = 1'b0;
        wr_valid_next = 1'b0;
        wr_data_next  = wr_data_reg;
        busy_next     = busy_reg;

        if (stop_det) begin
            state_next    = ST_IDLE;
            bit_cnt_next  = 4'd0;
            sda_oe_next   = 1'b0;
            ack_seen_next = 1'b0;
            req_sent_next = 1'b0;
            busy_next     = 1'b0;
        end else if (start_det) begin
            state_next    = ST_ADDR;
            bit_cnt_next  = 4'd0;
            rx_shift_next = 7'd0;
            sda_oe_next   = 1'b0;
            ack_seen_next = 1'b0;
            req_sent_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (scl_rise) begin
                        rx_shift_next = {rx_shift_reg[5:0], sda_s};
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            rw_next      = sda_s;
                            if (rx_shift_reg == SLAVE_ADDRESS) begin
                                state_next = ST_ADDR_ACK;
                                busy_next  = 1'b1;
                            end else begin
                                state_next = ST_WAIT_STOP;
                                busy_next  = 1'b0;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                // First fall after the 8th bit pulls SDA; the next fall ends the ACK slot.
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 4'd0;
                            if (state_reg == ST_WR_ACK) begin
                                state_next = ST_WR_DATA;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                                scl_oe_next = 1'b1;
`endif
                            end else begin
                                state_next = rw_reg ? ST_RD_LOAD : ST_WR_DATA;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        rx_shift_next = {rx_shift_reg[5:0], sda_s};
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next  = 4'd0;
                            wr_data_next  = {rx_shift_reg, sda_s};
                            wr_valid_next = 1'b1;
                            state_next    = ST_WR_ACK;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_RD_LOAD: begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                    req_sent_next = 1'b1;
                    if (rd_valid_i) begin
                        // SCL stays held one more cycle so SDA settles before release.
                        tx_shift_next = rd_data_i[6:0];
                        sda_oe_next   = ~rd_data_i[7];
                        bit_cnt_next  = 4'd0;
                        req_sent_next = 1'b0;
                        scl_oe_next   = 1'b1;
                        state_next    = ST_RD_DATA;
                    end else if (!scl_s) begin
                        scl_oe_next = 1'b1;
                    end
`else
                    tx_shift_next = rd_data_i[6:0];
                    sda_oe_next   = ~rd_data_i[7];
                    bit_cnt_next  = 4'd0;
                    state_next    = ST_RD_DATA;
`endif
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next   = 1'b0;
                            bit_cnt_next  = 4'd0;
                            ack_seen_next = 1'b0;
                            state_next    = ST_RD_ACK;
                        end else begin
                            sda_oe_next   = ~tx_shift_reg[6];
                            tx_shift_next = {tx_shift_reg[5:0], 1'b0};
                        end
                    end
                end
                // Master ACK is sampled on the rise but acted on at the fall, keeping SDA still while SCL is high.
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_next = ST_WAIT_STOP;
                            busy_next  = 1'b0;
                        end else begin
                            ack_seen_next = 1'b1;
                        end
                    end else if (scl_fall && ack_seen_reg) begin
                        ack_seen_next = 1'b0;
                        state_next    = ST_RD_LOAD;
                    end
                end
                ST_WAIT_STOP: sda_oe_next = 1'b0;
                default:      state_next  = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (areset) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 4'd0;
            rx_shift_reg <= 7'd0;
            tx_shift_reg <= 7'd0;
            rw_reg       <= 1'b0;
            ack_seen_reg <= 1'b0;
            req_sent_reg <= 1'b0;
            sda_oe_reg   <= 1'b0;
            scl_oe_reg   <= 1'b0;
            wr_valid_reg <= 1'b0;
            wr_data_reg  <= 8'd0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            rx_shift_reg <= rx_shift_next;
            tx_shift_reg <= tx_shift_next;
            rw_reg       <= rw_next;
            ack_seen_reg <= ack_seen_next;
            req_sent_reg <= req_sent_next;
            sda_oe_reg   <= sda_oe_next;
            scl_oe_reg   <= scl_oe_next;
            wr_valid_reg <= wr_valid_next;
            wr_data_reg  <= wr_data_next;
            busy_reg     <= busy_next;
        end
    end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    assign rd_req_o = (state_reg == ST_RD_LOAD) && !req_sent_reg;
`else
    logic unused_rd_valid;
    assign unused_rd_valid = rd_valid_i | req_sent_reg;
    assign rd_req_o        = (state_reg == ST_RD_LOAD);
`endif

    assign sda_oe_o   = sda_oe_reg;
    assign scl_oe_o   = scl_oe_reg;
    assign wr_valid_o = wr_valid_reg;
    assign wr_data_o  = wr_data_reg;
    assign busy_o     = busy_reg;
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-level I2C master, transaction-level expectations, per-cycle monitor.
module tb_i2c_slave_responder;
    localparam int LOW_CYC  = 12;
    localparam int HIGH_CYC = 12;

    logic       pclk = 1'b0;
    logic       areset;
    logic       scl_m, sda_m;
    logic       sda_oe_o, scl_oe_o, wr_valid_o, rd_req_o, rd_valid_i, busy_o;
    logic [7:0] wr_data_o, rd_data_i;
    logic       scl_line, sda_line;

    assign scl_line = scl_m & ~scl_oe_o;
    assign sda_line = sda_m & ~sda_oe_o;

    always #5 pclk = ~pclk;

    i2c_slave_responder dut (
        .pclk       (pclk),
        .areset     (areset),
        .scl_i      (scl_line),
        .sda_i      (sda_line),
        .sda_oe_o   (sda_oe_o),
        .scl_oe_o   (scl_oe_o),
        .wr_valid_o (wr_valid_o),
        .wr_data_o  (wr_data_o),
        .rd_req_o   (rd_req_o),
        .rd_valid_i (rd_valid_i),
        .rd_data_i  (rd_data_i),
        .busy_o     (busy_o)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_wr_q[$];
    logic [7:0] wr_log[$];
    logic [7:0] last_rd[$];
    logic [7:0] tx_bytes[8];
    logic [7:0] rd_mem[256];
    int         rd_push = 0;
    int         rd_pop = 0;
    int         rd_req_cnt = 0;
    int         exp_rd_req = 0;
    int         stretch_cyc = 0;
    logic       hold_chk = 1'b0;
    logic       sda_oe_seen = 1'b0;
    logic       prev_sda_oe = 1'b0;

    assign rd_data_i = rd_mem[rd_pop[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: write bytes against the scoreboard, bus rules, request counting.
    always @(negedge pclk) begin
        if (wr_valid_o) begin
            wr_log.push_back(wr_data_o);
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got byte 0x%0h with none expected", wr_data_o);
            end else begin
                check("wr_data", {24'd0, wr_data_o}, {24'd0, exp_wr_q.pop_front()});
            end
        end
        if (rd_req_o) rd_req_cnt++;
        if (scl_oe_o) stretch_cyc++;
        if (sda_oe_o) sda_oe_seen = 1'b1;
`ifndef I2C_SLAVE_CLK_STRETCH_EN
        if (scl_oe_o) check("scl_oe_tied_low", {31'd0, scl_oe_o}, 32'd0);
`endif
        if (hold_chk && (sda_oe_o != prev_sda_oe))
            check("sda_change_scl_low", {31'd0, scl_line}, 32'd0);
        prev_sda_oe = sda_oe_o;
    end

    // User read-data responder.
    initial begin
        rd_valid_i = 1'b0;
        forever begin
            @(negedge pclk);
            if (rd_req_o) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
                repeat (20) @(posedge pclk);
                #1 rd_valid_i = 1'b1;
                @(posedge pclk);
                #1 rd_valid_i = 1'b0;
                rd_pop++;
`else
                @(posedge pclk);
                #1 rd_pop++;
`endif
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic scl_high();
        int t;
        t = 0;
        scl_m = 1'b1;
        while (!scl_line && t < 2000) begin
            cyc(1);
            t++;
        end
        if (!scl_line) begin
            checks++;
            errors++;
            $display("FAIL scl_release_timeout: SCL still low after %0d cycles", t);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic s);
        cyc(3);
        sda_m = b;
        cyc(LOW_CYC - 3);
        scl_high();
        cyc(HIGH_CYC / 2);
        s = sda_line;
        cyc(HIGH_CYC / 2);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            cyc(LOW_CYC);
            sda_m = 1'b1;
            cyc(4);
            scl_high();
        end else begin
            sda_m = 1'b1;
        end
        cyc(6);
        sda_m = 1'b0;
        cyc(6);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(3);
        sda_m = 1'b0;
        cyc(LOW_CYC - 3);
        scl_high();
        cyc(6);
        sda_m = 1'b1;
        cyc(HIGH_CYC);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(~mack, s);
    endtask

    // One addressed transfer using tx_bytes[0..n-1]; expectations follow from the address alone.
    task automatic transfer(input logic [6:0] addr, input logic rw, input int n, input logic end_stop);
        logic       ack, match;
        logic [7:0] d;
        match = (addr == 7'h68);
        last_rd.delete();
        if (match && rw) begin
            for (int i = 0; i < n; i++) begin
                rd_mem[rd_push[7:0]] = tx_bytes[i];
                rd_push++;
            end
            exp_rd_req += n;
        end
        i2c_start();
        write_byte({addr, rw}, ack);
        check("addr_ack", {31'd0, ack}, {31'd0, match});
        check("busy_after_addr", {31'd0, busy_o}, {31'd0, match});
        if (match) begin
            for (int i = 0; i < n; i++) begin
                if (!rw) begin
                    exp_wr_q.push_back(tx_bytes[i]);
                    write_byte(tx_bytes[i], ack);
                    check("data_ack", {31'd0, ack}, 32'd1);
                end else begin
                    read_byte(i < n - 1, d);
                    last_rd.push_back(d);
                    check("rd_byte", {24'd0, d}, {24'd0, tx_bytes[i]});
                end
            end
            if (rw) check("busy_after_nack", {31'd0, busy_o}, 32'd0);
        end
        if (end_stop) begin
            i2c_stop();
            check("busy_after_stop", {31'd0, busy_o}, 32'd0);
        end
        $display("xfer addr=0x%02h rw=%0d n=%0d stop=%0d match=%0d", addr, rw, n, end_stop, match);
    endtask

    initial begin
        int         base, req0;
        logic       ack, s;
        logic [6:0] a;
        areset = 1'b1;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'h00;
        cyc(5);
        check("rst_sda_oe", {31'd0, sda_oe_o}, 32'd0);
        check("rst_scl_oe", {31'd0, scl_oe_o}, 32'd0);
        check("rst_wr_valid", {31'd0, wr_valid_o}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data_o}, 32'd0);
        check("rst_rd_req", {31'd0, rd_req_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        areset = 1'b0;
        cyc(5);
        hold_chk = 1'b1;

        // Write 0xA5, 0x3C to our address.
        base = wr_log.size();
        tx_bytes[0] = 8'hA5;
        tx_bytes[1] = 8'h3C;
        transfer(7'h68, 1'b0, 2, 1'b1);
        check("wr_count", wr_log.size() - base, 32'd2);
        if (wr_log.size() >= base + 2) begin
            check("wr_lit0", {24'd0, wr_log[base]}, 32'hA5);
            check("wr_lit1", {24'd0, wr_log[base+1]}, 32'h3C);
        end

        // Foreign address: never drives SDA.
        sda_oe_seen = 1'b0;
        tx_bytes[0] = 8'h77;
        transfer(7'h6C, 1'b0, 1, 1'b1);
        check("foreign_no_drive", {31'd0, sda_oe_seen}, 32'd0);

        // Read 0x5A then 0xC3, master ACK then NACK.
        req0 = rd_req_cnt;
        tx_bytes[0] = 8'h5A;
        tx_bytes[1] = 8'hC3;
        transfer(7'h68, 1'b1, 2, 1'b1);
        check("rd_req_pulses", rd_req_cnt - req0, 32'd2);
        if (last_rd.size() == 2) begin
            check("rd_lit0", {24'd0, last_rd[0]}, 32'h5A);
            check("rd_lit1", {24'd0, last_rd[1]}, 32'hC3);
        end

        // Write 0x11, repeated START, then read.
        base = wr_log.size();
        tx_bytes[0] = 8'h11;
        transfer(7'h68, 1'b0, 1, 1'b0);
        tx_bytes[0] = 8'h9E;
        transfer(7'h68, 1'b1, 1, 1'b1);
        check("rs_wr_count", wr_log.size() - base, 32'd1);
        if (wr_log.size() > base) check("rs_wr_lit", {24'd0, wr_log[base]}, 32'h11);

        // Reset while the target drives bit 3 (a 0) of a read byte.
        rd_mem[rd_push[7:0]] = 8'hF0;
        rd_push++;
        exp_rd_req++;
        i2c_start();
        write_byte({7'h68, 1'b1}, ack);
        check("rst_test_addr_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
        cyc(8);
        check("bit3_driven", {31'd0, sda_oe_o}, 32'd1);
        hold_chk = 1'b0;
        areset = 1'b1;
        cyc(1);
        check("rst_mid_sda_release", {31'd0, sda_oe_o}, 32'd0);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        areset = 1'b0;
        i2c_stop();
        cyc(4);
        hold_chk = 1'b1;
        $display("xfer reset-during-read done");

`ifdef I2C_SLAVE_CLK_STRETCH_EN
        stretch_cyc = 0;
        tx_bytes[0] = 8'h96;
        transfer(7'h68, 1'b1, 1, 1'b1);
        check("stretch_cycles", {31'd0, (stretch_cyc >= 20 && stretch_cyc <= 22)}, 32'd1);
        if (last_rd.size() == 1) check("stretch_byte", {24'd0, last_rd[0]}, 32'h96);
`endif

        // Randomized transfers.
        for (int t = 0; t < 14; t++) begin
            int   n;
            logic rw, st;
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h68;
            rw = 1'($urandom);
            n  = $urandom_range(1, 4);
            st = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) tx_bytes[i] = 8'($urandom);
            transfer(a, rw, n, st);
        end
        if (!scl_m) i2c_stop();
        cyc(10);

        check("wr_scoreboard_empty", exp_wr_q.size(), 32'd0);
        check("rd_req_total", rd_req_cnt, exp_rd_req);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
